sram_arbiter: RTL
=================

# sram_arbiter

Parametrised SRAM access scheduler for the video memory path. It time-multiplexes one asynchronous SRAM between a guaranteed video read stream and NUM_PORTS independent host ports. Each host port may read or write, and ports are served round-robin. It sits between the pixel fetch logic / host bus bridges and the external SRAM pins, adding per-port read/write selection, fair arbitration and completion handshakes for every port.

## Interface
- ADDR_WIDTH, 17, SRAM address width; all address arithmetic is modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, SRAM data width.
- NUM_PORTS, 2, number of host ports (1..8).
- clock  in  1  system clock; all registers update on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- videoAddress  in  ADDR_WIDTH  pixel fetch address.
- videoAddressOffset  in  ADDR_WIDTH  base offset added to the video address and to offset-enabled port addresses.
- videoData  out  DATA_WIDTH  last fetched video byte.
- videoDataReady  out  1  one-cycle pulse: videoData updated.
- portRequest  in  NUM_PORTS  per-port access request (level).
- portWrite  in  NUM_PORTS  1 = write, 0 = read; qualified by portRequest.
- portUseOffset  in  NUM_PORTS  1 = add videoAddressOffset to that port's address.
- portAddress  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- portWriteData  in  NUM_PORTS*DATA_WIDTH  packed write data.
- portReadData  out  NUM_PORTS*DATA_WIDTH  packed read data; each lane holds its value until that port's next read.
- portGrant  out  NUM_PORTS  one-hot; the port owning the current port slot.
- portDone  out  NUM_PORTS  one-cycle pulse: port access complete.
- ramAddress  out  ADDR_WIDTH  SRAM address.
- ramData  inout  DATA_WIDTH  SRAM data bus.
- ramOutputEnable  out  1  active-low SRAM output enable.
- ramWriteEnable  out  1  active-low SRAM write enable.

## Operation
- The state machine cycles unconditionally with a fixed 4-cycle frame: VIDEO_ADDR -> VIDEO_LATCH -> PORT_ADDR -> PORT_LATCH -> VIDEO_ADDR.
- All SRAM pins are registered and computed from the next state, so pin values are stable for the whole state cycle.
- **VIDEO_ADDR / VIDEO_LATCH**
  - ramAddress = videoAddress + videoAddressOffset. videoAddress is sampled at the edge entering VIDEO_ADDR.
  - ramOutputEnable = 0 and ramWriteEnable = 1 in both cycles; ramData is hi-Z.
  - The edge ending VIDEO_LATCH captures ramData into videoData.
- **Arbitration** happens at the edge entering PORT_ADDR, using portRequest as sampled during VIDEO_LATCH.
  - A round-robin pointer holds the last granted index. Search order is last+1, last+2, … with wrap-around modulo NUM_PORTS. The first requester found wins.
  - The pointer updates only when a grant is made.
  - If there is no requester, the slot is idle: OE = 1, WE = 1, ramData hi-Z, portGrant = 0, pointer unchanged.
- **Read grant (port i)**
  - ramAddress = portAddress[i] (+ offset if portUseOffset[i]).
  - OE = 0 during PORT_ADDR and PORT_LATCH.
  - The edge ending PORT_LATCH captures ramData into portReadData lane i.
- **Write grant (port i)**
  - Same address rule as a read.
  - ramData = portWriteData[i], driven during PORT_ADDR and PORT_LATCH.
  - WE = 0 during PORT_ADDR only, so WE rises one full cycle before the address and data change. OE = 1 throughout.
  - ramData is released at the edge entering VIDEO_ADDR.
- portGrant[i] is high during PORT_ADDR and PORT_LATCH.
- portDone[i] pulses during the following VIDEO_ADDR cycle. For a read, portReadData lane i is valid from that cycle.
- **Requester rules**
  - Hold portWrite, portUseOffset, portAddress and portWriteData stable from request until portDone.
  - Deassert portRequest in the cycle after portDone (VIDEO_LATCH). A request still high then is treated as a new access.
- **Reset** (asynchronous, may occur mid-frame):
  - The state returns to VIDEO_ADDR and the pointer is set to NUM_PORTS-1, so port 0 is searched first.
  - An in-flight access is aborted: no portDone is issued and the requester must reissue.
  - ramAddress = 0, ramOutputEnable = 1, ramWriteEnable = 1, ramData hi-Z.
  - videoData = 0, videoDataReady = 0, portReadData = 0, portGrant = 0, portDone = 0.
  - After reset is released, the first frame starts at VIDEO_ADDR on the next edge.

## Timing
- Video: one read per 4 cycles. videoDataReady pulses during PORT_ADDR, 2 cycles after the address is applied.
- Port latency, from the cycle where the request is sampled (VIDEO_LATCH) to portDone: 3 cycles minimum.
- Worst case with all ports requesting: each port is served once per 4*NUM_PORTS cycles, so no port starves.
- The video slot is never skipped or delayed by port activity.
- Address sums truncate silently, e.g. 0x1FFFF + 0x00002 = 0x00001 for ADDR_WIDTH = 17.

## Test plan
- **Reset mid-write:** assert reset during PORT_ADDR of a write -> WE = 1, ramData hi-Z and OE = 1 immediately, with no portDone; after release the first state is VIDEO_ADDR.
- **Video stream:** model SRAM with mem[a] = a[7:0]; set videoAddress = 0x00100 and offset = 0x00010 -> ramAddress = 0x00110 and videoData = 0x10, with videoDataReady pulsing exactly every 4 cycles.
- **Write then read on port 0:** write 0xA5 to 0x01234 (offset off), then read it back -> WE low for exactly one cycle with data 0xA5, portDone[0] pulses, then portReadData lane 0 = 0xA5.
- **Round-robin:** NUM_PORTS = 3 with all ports requesting continuously -> grant order 0, 1, 2, 0, 1, 2 and one grant per frame.
- **Offset and wrap:** a port 1 read with portUseOffset = 1, address 0x1FFFF and offset 0x00003 -> ramAddress = 0x00002.
- **Idle and back-to-back:** no requests for 3 frames -> OE and WE stay 1 in every port slot; then a port held requesting through portDone -> a second access is granted in the next frame.

Source files
------------

// File: rtl/sram_arbiter.sv
// Time-multiplexes one async SRAM between a fixed video read slot and NUM_PORTS round-robin host ports.
// Fixed 4-cycle frame, no backpressure: video every frame, at most one port access per frame, portDone 3 cycles after sampling.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           videoAddress,
  input  logic [ADDR_WIDTH-1:0]           videoAddressOffset,
  output logic [DATA_WIDTH-1:0]           videoData,
  output logic                            videoDataReady,
  input  logic [NUM_PORTS-1:0]            portRequest,
  input  logic [NUM_PORTS-1:0]            portWrite,
  input  logic [NUM_PORTS-1:0]            portUseOffset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] portAddress,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] portWriteData,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] portReadData,
  output logic [NUM_PORTS-1:0]            portGrant,
  output logic [NUM_PORTS-1:0]            portDone,
  output logic [ADDR_WIDTH-1:0]           ramAddress,
  inout  wire  [DATA_WIDTH-1:0]           ramData,
  output logic                            ramOutputEnable,
  output logic                            ramWriteEnable
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {VIDEO_ADDR, VIDEO_LATCH, PORT_ADDR, PORT_LATCH} state_t;

  state_t                state;
  logic                  started;
  logic [PW-1:0]         last;
  logic                  cur_vld;
  logic                  cur_wr;
  logic [PW-1:0]         cur_idx;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] drive_data;

  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         cand_idx;
  logic [ADDR_WIDTH-1:0] win_base;
  logic [ADDR_WIDTH-1:0] win_addr;
  int                    cand;

  assign ramData = drive_en ? drive_data : 'z;

  // Search last+1, last+2, ... so the most recently served port is tried last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand     = (int'(last) + k) % NUM_PORTS;
      cand_idx = PW'(cand);
      if (!win_found && portRequest[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    win_base = portAddress[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win_addr = portUseOffset[win_idx] ? win_base + videoAddressOffset : win_base;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= VIDEO_ADDR;
      started         <= 1'b0;
      last            <= PW'(NUM_PORTS - 1);
      cur_vld         <= 1'b0;
      cur_wr          <= 1'b0;
      cur_idx         <= '0;
      drive_en        <= 1'b0;
      drive_data      <= '0;
      ramAddress      <= '0;
      ramOutputEnable <= 1'b1;
      ramWriteEnable  <= 1'b1;
      videoData       <= '0;
      videoDataReady  <= 1'b0;
      portReadData    <= '0;
      portGrant       <= '0;
      portDone        <= '0;
    end else begin
      videoDataReady <= 1'b0;
      portDone       <= '0;
      // The first edge after reset enters VIDEO_ADDR just like the end of a port slot.
      if (!started || state == PORT_LATCH) begin
        state           <= VIDEO_ADDR;
        started         <= 1'b1;
        ramAddress      <= videoAddress + videoAddressOffset;
        ramOutputEnable <= 1'b0;
        ramWriteEnable  <= 1'b1;
        drive_en        <= 1'b0;
        portGrant       <= '0;
        cur_vld         <= 1'b0;
        if (cur_vld) begin
          portDone <= NUM_PORTS'(1) << cur_idx;
          if (!cur_wr)
            portReadData[int'(cur_idx)*DATA_WIDTH +: DATA_WIDTH] <= ramData;
        end
      end else begin
        case (state)
          VIDEO_ADDR: state <= VIDEO_LATCH;
          VIDEO_LATCH: begin
            state          <= PORT_ADDR;
            videoData      <= ramData;
            videoDataReady <= 1'b1;
            if (win_found) begin
              last            <= win_idx;
              cur_vld         <= 1'b1;
              cur_idx         <= win_idx;
              cur_wr          <= portWrite[win_idx];
              portGrant       <= NUM_PORTS'(1) << win_idx;
              ramAddress      <= win_addr;
              ramOutputEnable <= portWrite[win_idx];
              ramWriteEnable  <= !portWrite[win_idx];
              drive_en        <= portWrite[win_idx];
              drive_data      <= portWriteData[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
              ramOutputEnable <= 1'b1;
              ramWriteEnable  <= 1'b1;
            end
          end
          // WE rises a full cycle before address and data move.
          PORT_ADDR: begin
            state          <= PORT_LATCH;
            ramWriteEnable <= 1'b1;
          end
          default: state <= VIDEO_ADDR;
        endcase
      end
    end
  end

endmodule
